// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ctrl
// Description : HD44780-compatible character-LCD controller. It consumes the
//               LSU io_lcd word and drives the LCD pins with setup, enable
//               pulse, hold and execution timing. After reset it waits for
//               power-up, runs a fixed four-command init sequence, then
//               executes one software command per toggle of io_lcd_i[30].
//
// Ports       : clk_i        in   system clock (rising edge)
//               rst_i        in   asynchronous active-high reset
//               io_lcd_i     in   [31] ON, [30] toggle, [9] RS, [7:0] DATA
//               lcd_busy_o   out  high in every state except IDLE
//               init_done_o  out  sticky flag, set when init completes
//               lcd_on_o     out  registered copy of io_lcd_i[31]
//               lcd_en_o     out  LCD enable strobe (registered)
//               lcd_rs_o     out  LCD register select
//               lcd_rw_o     out  LCD read/write, tied low (write only)
//               lcd_data_o   out  LCD data bus
//
// Revision    : 1.0  initial release
// ============================================================================
module lcd_ctrl #(
    parameter int unsigned T_POWERUP   = 2_000_000,
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_PULSE     = 12,
    parameter int unsigned T_HOLD      = 2,
    parameter int unsigned T_EXEC      = 2_000,
    parameter int unsigned T_EXEC_LONG = 82_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] io_lcd_i,
    output logic        lcd_busy_o,
    output logic        init_done_o,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o
);

    // Counter is sized for the largest timing parameter plus one bit.
    localparam int unsigned C_MAX_A = (T_POWERUP > T_EXEC_LONG) ? T_POWERUP : T_EXEC_LONG;
    localparam int unsigned C_MAX_B = (T_EXEC > T_PULSE) ? T_EXEC : T_PULSE;
    localparam int unsigned C_MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
    localparam int unsigned C_MAX_D = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
    localparam int unsigned C_MAX_T = (C_MAX_D > C_MAX_C) ? C_MAX_D : C_MAX_C;
    localparam int unsigned C_CW    = $clog2(C_MAX_T) + 1;

    typedef logic [C_CW-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_POWERUP = 3'd0,
        S_IDLE    = 3'd1,
        S_SETUP   = 3'd2,
        S_PULSE   = 3'd3,
        S_HOLD    = 3'd4,
        S_EXEC    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    cnt_t        cnt_q,   cnt_d;
    logic        en_q,    en_d;
    logic        rs_q,    rs_d;
    logic [7:0]  data_q,  data_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic        on_q,    on_d;
    logic        tog_q,   tog_d;
    logic [1:0]  idx_q,   idx_d;

    logic        w_last;
    logic        w_unused_io;

    // Only ON, toggle, RS and DATA are meaningful in the LSU word.
    assign w_unused_io = ^{io_lcd_i[29:10], io_lcd_i[8]};

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;   // 8-bit bus, 2 lines, 5x8 font
            2'd1:    cmd = 8'h0C;   // display on, cursor off
            2'd2:    cmd = 8'h01;   // clear display
            default: cmd = 8'h06;   // entry mode: increment, no shift
        endcase
        return cmd;
    endfunction

    // Clear (01) and return-home (02/03) need the long execution wait.
    function automatic cnt_t exec_time(input logic rs, input logic [7:0] data);
        cnt_t t;
        if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03)) begin
            t = cnt_t'(T_EXEC_LONG);
        end else begin
            t = cnt_t'(T_EXEC);
        end
        return t;
    endfunction

    // A state loaded with N stays for exactly N cycles: it leaves on the
    // edge where the counter reads 1.
    assign w_last = (cnt_q == cnt_t'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - cnt_t'(1);
        en_d    = en_q;
        rs_d    = rs_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        on_d    = io_lcd_i[31];
        tog_d   = tog_q;
        idx_d   = idx_q;

        case (state_q)
            S_POWERUP: begin
                if (w_last) begin
                    state_d = S_SETUP;
                    cnt_d   = cnt_t'(T_SETUP);
                    rs_d    = 1'b0;
                    data_d  = init_cmd(2'd0);
                end
            end

            S_IDLE: begin
                cnt_d = cnt_q;
                // A toggle mismatch left over from a busy period is taken
                // here too, with whatever word is present this cycle.
                if (io_lcd_i[30] != tog_q) begin
                    tog_d   = io_lcd_i[30];
                    rs_d    = io_lcd_i[9];
                    data_d  = io_lcd_i[7:0];
                    state_d = S_SETUP;
                    cnt_d   = cnt_t'(T_SETUP);
                    busy_d  = 1'b1;
                end
            end

            S_SETUP: begin
                if (w_last) begin
                    state_d = S_PULSE;
                    cnt_d   = cnt_t'(T_PULSE);
                    en_d    = 1'b1;
                end
            end

            S_PULSE: begin
                if (w_last) begin
                    state_d = S_HOLD;
                    cnt_d   = cnt_t'(T_HOLD);
                    en_d    = 1'b0;
                end
            end

            S_HOLD: begin
                if (w_last) begin
                    state_d = S_EXEC;
                    cnt_d   = exec_time(rs_q, data_q);
                end
            end

            S_EXEC: begin
                if (w_last) begin
                    if (!done_q && idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        rs_d    = 1'b0;
                        data_d  = init_cmd(idx_q + 2'd1);
                        state_d = S_SETUP;
                        cnt_d   = cnt_t'(T_SETUP);
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_POWERUP;
                cnt_d   = cnt_t'(T_POWERUP);
                en_d    = 1'b0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_POWERUP;
            cnt_q   <= cnt_t'(T_POWERUP);
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
            tog_q   <= 1'b0;
            idx_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            on_q    <= on_d;
            tog_q   <= tog_d;
            idx_q   <= idx_d;
        end
    end

    assign lcd_busy_o  = busy_q;
    assign init_done_o = done_q;
    assign lcd_on_o    = on_q;
    assign lcd_en_o    = en_q;
    assign lcd_rs_o    = rs_q;
    assign lcd_rw_o    = 1'b0;
    assign lcd_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_ctrl
// Description : Self-checking bench for lcd_ctrl with short timing values.
//               Expected LCD writes and their durations are derived from the
//               command timing rules with plain arithmetic.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_ctrl;

    localparam int T_POWERUP   = 10;
    localparam int T_SETUP     = 2;
    localparam int T_PULSE     = 4;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 8;
    localparam int T_EXEC_LONG = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] io_lcd = 32'h0;
    logic        busy, done, on, en, rs, rw;
    logic [7:0]  data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int inj_cyc = -1;
    logic [31:0] inj_val = 32'h0;
    logic        tog = 1'b0;
    logic [7:0]  init_list [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    lcd_ctrl #(
        .T_POWERUP   (T_POWERUP),
        .T_SETUP     (T_SETUP),
        .T_PULSE     (T_PULSE),
        .T_HOLD      (T_HOLD),
        .T_EXEC      (T_EXEC),
        .T_EXEC_LONG (T_EXEC_LONG)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .io_lcd_i    (io_lcd),
        .lcd_busy_o  (busy),
        .init_done_o (done),
        .lcd_on_o    (on),
        .lcd_en_o    (en),
        .lcd_rs_o    (rs),
        .lcd_rw_o    (rw),
        .lcd_data_o  (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference timing: a write costs setup+pulse+hold plus its exec wait.
    function automatic int exec_cycles(input logic r, input logic [7:0] d);
        if (!r && d >= 8'h01 && d <= 8'h03) return T_EXEC_LONG;
        return T_EXEC;
    endfunction

    function automatic int cmd_cycles(input logic r, input logic [7:0] d);
        return T_SETUP + T_PULSE + T_HOLD + exec_cycles(r, d);
    endfunction

    // Advance one edge and sample 1 time unit later; software-side writes
    // scheduled at a given cycle are applied here.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == inj_cyc) begin
            io_lcd  = inj_val;
            inj_cyc = -1;
        end
    endtask

    // Called just after the edge that starts a write (SETUP entry). Follows
    // the write to its end and checks the pin-level waveform.
    task automatic expect_cmd(input string tag, input logic exp_rs, input logic [7:0] exp_d,
                              input logic busy_end, input logic done_end);
        int total;
        int busy_cnt;
        int en_cnt;
        int en_first;
        logic [7:0] cap_d;
        logic       cap_rs;
        total    = cmd_cycles(exp_rs, exp_d);
        busy_cnt = 0;
        en_cnt   = 0;
        en_first = -1;
        cap_d    = 8'hxx;
        cap_rs   = 1'bx;
        check({tag, " on"}, 32'(on), 32'(io_lcd[31]));
        check({tag, " rw"}, 32'(rw), 32'h0);
        for (int j = 0; j < total; j++) begin
            if (busy === 1'b1) busy_cnt++;
            if (en === 1'b1) begin
                if (en_first < 0) begin
                    en_first = j;
                    cap_d    = data;
                    cap_rs   = rs;
                end
                en_cnt++;
            end
            tick();
        end
        check({tag, " busy_cycles"}, busy_cnt, total);
        check({tag, " en_high"}, en_cnt, T_PULSE);
        check({tag, " en_setup"}, en_first, T_SETUP);
        check({tag, " rs"}, 32'(cap_rs), 32'(exp_rs));
        check({tag, " data"}, 32'(cap_d), 32'(exp_d));
        check({tag, " busy_end"}, 32'(busy), 32'(busy_end));
        check({tag, " done_end"}, 32'(done), 32'(done_end));
        check({tag, " en_end"}, 32'(en), 32'h0);
    endtask

    task automatic run_init(input string tag);
        int bad;
        int init_total;
        bad = 0;
        init_total = T_POWERUP;
        for (int i = 0; i < 4; i++) init_total += cmd_cycles(1'b0, init_list[i]);
        for (int k = 0; k < T_POWERUP; k++) begin
            if (busy !== 1'b1 || en !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        check({tag, " powerup_quiet"}, bad, 0);
        for (int i = 0; i < 4; i++) begin
            expect_cmd($sformatf("%s cmd%0d", tag, i), 1'b0, init_list[i],
                       (i == 3) ? 1'b0 : 1'b1, (i == 3) ? 1'b1 : 1'b0);
        end
        check({tag, " total_cycles"}, cyc, init_total);
    endtask

    task automatic send_word(input logic [31:0] w);
        io_lcd = w;
        tog    = w[30];
        tick();
    endtask

    function automatic logic [31:0] make_word(input logic o, input logic t,
                                              input logic r, input logic [7:0] d);
        return {o, t, 20'($urandom), r, 1'($urandom), d};
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " en"}, 32'(en), 32'h0);
        check({tag, " rs"}, 32'(rs), 32'h0);
        check({tag, " rw"}, 32'(rw), 32'h0);
        check({tag, " data"}, 32'(data), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h1);
        check({tag, " done"}, 32'(done), 32'h0);
        check({tag, " on"}, 32'(on), 32'h0);
    endtask

    initial begin
        logic       r_rs, r_rs2;
        logic [7:0] r_d, r_d2;
        logic       last_rs;
        logic [7:0] last_d;
        int         gap;
        logic       saw_en;

        // Reset with no stimulus, then the power-up/init sequence.
        rst = 1'b1;
        io_lcd = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        cyc = 0;
        run_init("init1");

        // First software command, accepted on the very next edge.
        send_word(32'hC000_0241);
        expect_cmd("cmd41", 1'b1, 8'h41, 1'b0, 1'b1);

        // Long (clear, RS=0) versus normal (RS=1) execution waits.
        send_word(32'h8000_0001);
        expect_cmd("long01", 1'b0, 8'h01, 1'b0, 1'b1);
        send_word(32'hC000_0201);
        expect_cmd("data01", 1'b1, 8'h01, 1'b0, 1'b1);
        last_rs = 1'b1;
        last_d  = 8'h01;

        // Random commands with random idle gaps (gap 0 = back to back).
        for (int n = 0; n < 8; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                repeat (gap) tick();
                check($sformatf("rand%0d idle_busy", n), 32'(busy), 32'h0);
                check($sformatf("rand%0d idle_en", n), 32'(en), 32'h0);
                check($sformatf("rand%0d idle_rs", n), 32'(rs), 32'(last_rs));
                check($sformatf("rand%0d idle_data", n), 32'(data), 32'(last_d));
            end
            r_rs = 1'($urandom_range(0, 1));
            r_d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send_word(make_word(1'($urandom), ~tog, r_rs, r_d));
            expect_cmd($sformatf("rand%0d", n), r_rs, r_d, 1'b0, 1'b1);
            last_rs = r_rs;
            last_d  = r_d;
        end

        // Toggle 5 cycles into EXEC; the command runs on the first IDLE
        // edge using the word present in that cycle.
        r_rs = 1'b1;
        r_d  = 8'($urandom);
        send_word(make_word(1'b1, ~tog, r_rs, r_d));
        inj_val = make_word(1'b1, ~tog, 1'b0, 8'h55);
        tog     = ~tog;
        inj_cyc = cyc + T_SETUP + T_PULSE + T_HOLD + 5;
        expect_cmd("busy_first", r_rs, r_d, 1'b0, 1'b1);
        r_rs2  = 1'($urandom_range(0, 1));
        r_d2   = 8'($urandom);
        io_lcd = {io_lcd[31:10], r_rs2, io_lcd[8], r_d2};
        tick();
        expect_cmd("busy_late", r_rs2, r_d2, 1'b0, 1'b1);

        // Reset while EN is high.
        send_word(make_word(1'b1, ~tog, 1'b1, 8'h5A));
        saw_en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (en === 1'b1) begin
                saw_en = 1'b1;
                break;
            end
            tick();
        end
        check("midpulse en_seen", 32'(saw_en), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midpulse");
        io_lcd = 32'h0;
        tog    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Toggle during init at cycle 20; must run only once init is done.
        r_rs = 1'($urandom_range(0, 1));
        r_d  = 8'($urandom_range(16, 255));
        inj_val = make_word(1'b1, 1'b1, r_rs, r_d);
        tog     = 1'b1;
        inj_cyc = 20;
        run_init("init2");
        tick();
        check("init2 pending_busy", 32'(busy), 32'h1);
        expect_cmd("init2 pending", r_rs, r_d, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_ctrl.md
# lcd_ctrl

HD44780-compatible character-LCD controller that consumes the memory-mapped `io_lcd` word written by the load-store unit and drives the physical LCD pins with correct setup, enable-pulse, hold and execution timing. On reset it runs a fixed power-up initialisation sequence. After that it executes one software command per toggle of a handshake bit, and reports a busy flag that the load path muxes back for software polling. It sits between the LSU's `io_lcd` register and the board's LCD header.

## Interface
- `T_POWERUP`, 2_000_000: cycles waited after reset before the first init command (40 ms at 50 MHz).
- `T_SETUP`, 2: cycles RS/DATA are stable before EN rises.
- `T_PULSE`, 12: cycles EN is high.
- `T_HOLD`, 2: cycles RS/DATA are held after EN falls.
- `T_EXEC`, 2_000: execution wait for normal commands and data.
- `T_EXEC_LONG`, 82_000: execution wait for clear/home commands.

Ports:
- `clk_i`  in  1  system clock; every register is rising-edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `io_lcd_i`  in  32  LSU LCD register: [31] ON, [30] command toggle, [9] RS, [7:0] DATA; other bits are ignored.
- `lcd_busy_o`  out  1  high while powering up, initialising or executing a command.
- `init_done_o`  out  1  high once the init sequence has completed; sticky until reset.
- `lcd_on_o`  out  1  registered copy of `io_lcd_i[31]`.
- `lcd_en_o`  out  1  LCD enable strobe.
- `lcd_rs_o`  out  1  LCD register select.
- `lcd_rw_o`  out  1  LCD read/write; constant 0 (write only).
- `lcd_data_o`  out  8  LCD data bus.

## Operation
- States: POWERUP, IDLE, SETUP, PULSE, HOLD, EXEC.
- One down-counter times every state; its width is `$clog2` of the largest parameter plus 1.
- Reset values:
  - state = POWERUP, counter = `T_POWERUP`.
  - `lcd_en_o` = 0, `lcd_rs_o` = 0, `lcd_rw_o` = 0, `lcd_data_o` = 8'h00.
  - `lcd_busy_o` = 1, `init_done_o` = 0, `lcd_on_o` = 0.
  - Toggle register `tog_q` = 0, init index = 0.
- POWERUP: counts `T_POWERUP` cycles, then loads init command 0 and enters SETUP.
- Init sequence, all with RS=0, in this order: 8'h38, 8'h0C, 8'h01, 8'h06.
- Write engine:
  - SETUP: EN=0 with RS/DATA driven, for `T_SETUP` cycles.
  - PULSE: EN=1, for `T_PULSE` cycles.
  - HOLD: EN=0, for `T_HOLD` cycles.
  - EXEC: EN=0, wait for the execution time.
- Execution time is `T_EXEC_LONG` when RS=0 and DATA is in {8'h01, 8'h02, 8'h03}; otherwise `T_EXEC`.
- EXEC exit:
  - If init index < 3: increment the index, load the next init command, go to SETUP.
  - After the 4th init command: set `init_done_o`, go to IDLE.
  - After a software command: go to IDLE.
- IDLE, when `io_lcd_i[30]` != `tog_q`:
  - Latch RS = `io_lcd_i[9]` and DATA = `io_lcd_i[7:0]`.
  - Set `tog_q` = `io_lcd_i[30]`.
  - Go to SETUP.
- Toggle changes while not in IDLE (including POWERUP and init) are not lost. The mismatch persists and is accepted in the first IDLE cycle, using the `io_lcd_i` value present in that cycle.
- If software toggles twice while busy, the net mismatch is zero and no command runs. Software must poll `lcd_busy_o` before each write.
- `lcd_on_o` updates every cycle, independent of state.
- `lcd_rs_o` and `lcd_data_o` keep their last values in IDLE.

## Timing
- `lcd_busy_o` is registered: 1 in every state except IDLE. It goes to 1 on the clock edge that leaves IDLE and to 0 on the edge that enters IDLE.
- Accepted command: exactly `T_SETUP` + `T_PULSE` + `T_HOLD` + exec cycles from the acceptance edge to re-entry into IDLE.
- Back-to-back commands: the minimum gap between the IDLE entry edge and the next acceptance edge is 1 cycle.
- `lcd_en_o` is a registered output with no glitches. Its high time is exactly `T_PULSE` cycles.
- Init total: `T_POWERUP` + 4×(`T_SETUP` + `T_PULSE` + `T_HOLD`) + 3×`T_EXEC` + `T_EXEC_LONG` cycles. `init_done_o` rises on the same edge on which `lcd_busy_o` falls.
- Reset asserted at any point (mid-pulse included):
  - `lcd_en_o` drops immediately (asynchronously).
  - All outputs take their reset values.
  - The sequence restarts from POWERUP after reset deasserts.

## Test plan
All scenarios use `T_POWERUP`=10, `T_SETUP`=2, `T_PULSE`=4, `T_HOLD`=2, `T_EXEC`=8, `T_EXEC_LONG`=20, with `io_lcd_i`=0.
- Reset release, no stimulus:
  - Four EN pulses with data 38, 0C, 01, 06 and RS=0, each EN high for exactly 4 cycles.
  - Gap after the 01 pulse is 20 exec cycles; gap after the other pulses is 8.
  - `init_done_o` rises and busy falls 10+32+44=86 cycles after reset release.
- After init, `io_lcd_i`=32'hC000_0241:
  - Accepted next edge; `lcd_rs_o`=1, `lcd_data_o`=8'h41; EN high 4 cycles.
  - Busy high for 16 cycles; `lcd_on_o`=1.
- Long vs normal exec:
  - `io_lcd_i`=32'h8000_0001 (toggle back to 0, RS=0): busy for 28 cycles.
  - Then 32'hC000_0201 (RS=1): busy for 16 cycles.
- Write during busy: toggle to a new command 5 cycles into EXEC. It is accepted on the first IDLE edge, with data taken from the current `io_lcd_i`.
- Write during init: toggle at cycle 20 after reset. The command executes immediately after `init_done_o` rises, and not earlier.
- Reset asserted while `lcd_en_o`=1:
  - EN=0 and busy=1 immediately.
  - After release, the POWERUP and init sequence repeats exactly as in scenario 1.
